// File: rtl/op_fifo_arbiter_if.sv
// Handshake bundle between the per-switch operation FIFOs, the round-robin arbiter and op_sif.
// master: the arbiter side. slave: the FIFO/op_sif environment side.
interface op_fifo_arbiter_if #(
  parameter int NUM_SW_INST = 5,
  parameter int OP_WIDTH    = 32,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 16
);
  logic                            enable;
  logic [NUM_SW_INST-1:0]          fifo_empty;
  logic [NUM_SW_INST*OP_WIDTH-1:0] fifo_data;
  logic [NUM_SW_INST-1:0]          fifo_rd_en;
  logic [OP_WIDTH-1:0]             op_out;
  logic [IDX_W-1:0]                fifo_idx;
  logic                            valid_out;
  logic                            busy;
  logic [CNT_W-1:0]                issued_cnt;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_en, op_out, fifo_idx, valid_out, busy, issued_cnt
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_en, op_out, fifo_idx, valid_out, busy, issued_cnt
  );
endinterface

// File: rtl/op_fifo_arbiter.sv
// Round-robin scheduler popping one op per round from the per-switch FIFOs into op_sif.
// Optional issued-op counter enabled by defining OP_ARB_STATS_EN.
module op_fifo_arbiter #(
  parameter int NUM_SW_INST = 5,
  parameter int OP_WIDTH    = 32,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  op_fifo_arbiter_if.master     bus
);
  localparam int unsigned N  = NUM_SW_INST;
  localparam int          GW = (NUM_SW_INST > 2) ? $clog2(NUM_SW_INST) : 1;

  typedef enum logic [1:0] {ARB, RD, OUT, HOLD} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant;
  logic          grant_valid;

  // Search starts just past the previous winner, so every requester is served in turn.
  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && !bus.fifo_empty[idx]) begin
        grant       = GW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  // Pop strobe is combinational so the FIFO data is ready in the following RD cycle.
  always_comb begin
    bus.fifo_rd_en = '0;
    if (!rst && state == ARB && bus.enable && grant_valid)
      bus.fifo_rd_en[grant] = 1'b1;
  end

  assign bus.busy = (state != ARB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      last_grant    <= GW'(N - 1);
      bus.op_out    <= '0;
      bus.fifo_idx  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          bus.valid_out <= 1'b0;
          if (bus.enable && grant_valid) begin
            last_grant <= grant;
            state      <= RD;
          end
        end
        RD: begin
          bus.op_out    <= bus.fifo_data[32'(last_grant)*OP_WIDTH +: OP_WIDTH];
          bus.fifo_idx  <= IDX_W'(last_grant);
          bus.valid_out <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          bus.valid_out <= 1'b0;
          state         <= HOLD;
        end
        HOLD: begin
          bus.valid_out <= 1'b0;
          state         <= ARB;
        end
        default: begin
          bus.valid_out <= 1'b0;
          state         <= ARB;
        end
      endcase
    end
  end

`ifdef OP_ARB_STATS_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (state == RD) cnt <= cnt + 1'b1;
  end

  assign bus.issued_cnt = cnt;
`else
  assign bus.issued_cnt = '0;
`endif

endmodule

// File: tb/tb_op_fifo_arbiter.sv
// Directed self-checking bench for op_fifo_arbiter (5 FIFOs, 32-bit ops).
// Counter expectations follow OP_ARB_STATS_EN as defined for the build.
module tb_op_fifo_arbiter;
  localparam int NSW = 5;
  localparam int OPW = 32;
  localparam int IXW = 3;
  localparam int CNW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  op_fifo_arbiter_if #(.NUM_SW_INST(NSW), .OP_WIDTH(OPW), .IDX_W(IXW), .CNT_W(CNW)) bus ();

  op_fifo_arbiter #(.NUM_SW_INST(NSW), .OP_WIDTH(OPW), .IDX_W(IXW), .CNT_W(CNW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [OPW-1:0] data [NSW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Expects to be entered in ARB with inputs that grant FIFO g; returns in the next ARB cycle.
  task automatic issue(input int g, input logic [OPW-1:0] d);
    logic [NSW-1:0] onehot;
    onehot = '0;
    onehot[g] = 1'b1;
    #1;
    check("grant_rd_en", 64'(bus.fifo_rd_en), 64'(onehot));
    check("arb_busy", 64'(bus.busy), 64'd0);
    tick();
    check("rd_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rd_valid", 64'(bus.valid_out), 64'd0);
    check("rd_busy", 64'(bus.busy), 64'd1);
    tick();
    check("out_valid", 64'(bus.valid_out), 64'd1);
    check("out_op", 64'(bus.op_out), 64'(d));
    check("out_idx", 64'(bus.fifo_idx), 64'(g));
    tick();
    check("hold_valid", 64'(bus.valid_out), 64'd0);
    check("hold_op", 64'(bus.op_out), 64'(d));
    check("hold_idx", 64'(bus.fifo_idx), 64'(g));
    check("hold_busy", 64'(bus.busy), 64'd1);
    tick();
  endtask

  logic [CNW-1:0] cnt_exp3;

  initial begin
    for (int i = 0; i < NSW; i++) data[i] = 32'hA0A0_0000 | 32'(i);
    data[2] = 32'h0006_A105;
    for (int i = 0; i < NSW; i++) bus.fifo_data[i*OPW +: OPW] = data[i];
`ifdef OP_ARB_STATS_EN
    cnt_exp3 = 16'd3;
`else
    cnt_exp3 = 16'd0;
`endif

    // Reset with everything empty
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.fifo_empty = '1;
    tick();
    tick();
    check("rst_op", 64'(bus.op_out), 64'd0);
    check("rst_idx", 64'(bus.fifo_idx), 64'd0);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cnt", 64'(bus.issued_cnt), 64'd0);
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("empty_valid", 64'(bus.valid_out), 64'd0);
      check("empty_busy", 64'(bus.busy), 64'd0);
    end

    // Single requester FIFO 2, issued twice back to back
    bus.fifo_empty = 5'b11011;
    issue(2, 32'h0006_A105);
    issue(2, 32'h0006_A105);
    bus.fifo_empty = '1;
    #1;
    check("drain_rd_en", 64'(bus.fifo_rd_en), 64'd0);

    // All FIFOs busy from reset: 0,1,2,3,4,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.fifo_empty = '0;
    for (int i = 0; i < 7; i++) issue(i % NSW, data[i % NSW]);

    // FIFOs 1 and 3: last_grant=1 -> 3, then 1, then 3
    bus.fifo_empty = 5'b10101;
    issue(3, data[3]);
    issue(1, data[1]);
    issue(3, data[3]);
    // Wrap 4 -> 0
    bus.fifo_empty = 5'b01110;
    issue(4, data[4]);
    issue(0, data[0]);

    // enable dropped in RD: op completes, no further grant until re-enabled
    bus.fifo_empty = '0;
    #1;
    check("en_grant", 64'(bus.fifo_rd_en), 64'b00010);
    tick();
    bus.enable = 1'b0;
    tick();
    check("en_out_valid", 64'(bus.valid_out), 64'd1);
    check("en_out_idx", 64'(bus.fifo_idx), 64'd1);
    check("en_out_op", 64'(bus.op_out), 64'(data[1]));
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("en_off_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("en_off_busy", 64'(bus.busy), 64'd0);
      tick();
    end
    bus.enable = 1'b1;
    issue(2, data[2]);

    // Counter and reset during OUT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(0, data[0]);
    issue(1, data[1]);
    issue(2, data[2]);
    check("cnt_three", 64'(bus.issued_cnt), 64'(cnt_exp3));
    #1;
    check("pre_rst_grant", 64'(bus.fifo_rd_en), 64'b01000);
    tick();
    tick();
    check("pre_rst_valid", 64'(bus.valid_out), 64'd1);
    rst = 1'b1;
    tick();
    #1;
    check("midrst_valid", 64'(bus.valid_out), 64'd0);
    check("midrst_op", 64'(bus.op_out), 64'd0);
    check("midrst_idx", 64'(bus.fifo_idx), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_cnt", 64'(bus.issued_cnt), 64'd0);
    check("midrst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    rst = 1'b0;
    issue(0, data[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
